// File: rtl/mem_arbiter.sv
// Arbitrates the single main-memory port between Icache line reads and Dcache reads/writebacks.
// Define ARB_ROUND_ROBIN_EN to alternate Icache/Dcache reads on ties; writebacks always win.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [LINE_W-1:0] dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {IDLE, DC_WR, DC_RD, IC_RD, ACK} state_t;

  state_t              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_out_q, mem_data_out_d;
  logic [LINE_W-1:0]   ic_read_data_q, ic_read_data_d;
  logic [LINE_W-1:0]   dc_read_data_q, dc_read_data_d;
  logic                ic_read_ack_q, ic_read_ack_d;
  logic                dc_read_ack_q, dc_read_ack_d;
  logic                dc_write_ack_q, dc_write_ack_d;
  logic                grant_ic, grant_dc;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_ic_q, last_ic_d;
`endif

  // Read-side choice; only consulted in IDLE when no writeback is waiting.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_ic = ic_read_req && (!dc_read_req || !last_ic_q);
`else
    grant_ic = ic_read_req && !dc_read_req;
`endif
    grant_dc = dc_read_req && !grant_ic;
  end

  always_comb begin
    state_d        = state_q;
    mem_enable_d   = mem_enable_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_data_out_d = mem_data_out_q;
    ic_read_data_d = ic_read_data_q;
    dc_read_data_d = dc_read_data_q;
    ic_read_ack_d  = 1'b0;
    dc_read_ack_d  = 1'b0;
    dc_write_ack_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_ic_d      = last_ic_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (dc_write_req) begin
          state_d        = DC_WR;
          mem_enable_d   = 1'b1;
          mem_rw_d       = 1'b1;
          mem_addr_d     = dc_write_addr;
          mem_data_out_d = dc_write_data;
        end else if (grant_dc) begin
          state_d      = DC_RD;
          mem_enable_d = 1'b1;
          mem_rw_d     = 1'b0;
          mem_addr_d   = dc_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
          last_ic_d    = 1'b0;
`endif
        end else if (grant_ic) begin
          state_d      = IC_RD;
          mem_enable_d = 1'b1;
          mem_rw_d     = 1'b0;
          mem_addr_d   = ic_read_addr;
`ifdef ARB_ROUND_ROBIN_EN
          last_ic_d    = 1'b1;
`endif
        end
      end
      DC_WR, DC_RD, IC_RD: begin
        if (mem_ack) begin
          state_d      = ACK;
          mem_enable_d = 1'b0;
          if (state_q == DC_WR) begin
            dc_write_ack_d = 1'b1;
          end else if (state_q == DC_RD) begin
            dc_read_ack_d  = 1'b1;
            dc_read_data_d = mem_data_in;
          end else begin
            ic_read_ack_d  = 1'b1;
            ic_read_data_d = mem_data_in;
          end
        end
      end
      // Skipping a grant here lets the served requester drop its req first.
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      mem_enable_q   <= 1'b0;
      mem_rw_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      ic_read_data_q <= '0;
      dc_read_data_q <= '0;
      ic_read_ack_q  <= 1'b0;
      dc_read_ack_q  <= 1'b0;
      dc_write_ack_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ic_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      mem_enable_q   <= mem_enable_d;
      mem_rw_q       <= mem_rw_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      ic_read_data_q <= ic_read_data_d;
      dc_read_data_q <= dc_read_data_d;
      ic_read_ack_q  <= ic_read_ack_d;
      dc_read_ack_q  <= dc_read_ack_d;
      dc_write_ack_q <= dc_write_ack_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_ic_q      <= last_ic_d;
`endif
    end
  end

  assign mem_enable   = mem_enable_q;
  assign mem_rw       = mem_rw_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;
  assign ic_read_data = ic_read_data_q;
  assign dc_read_data = dc_read_data_q;
  assign ic_read_ack  = ic_read_ack_q;
  assign dc_read_ack  = dc_read_ack_q;
  assign dc_write_ack = dc_write_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed grant-order table, reset/spurious-ack
// sequences, and randomized request mixes scored against a priority-rule model.
module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int WR = 0;
  localparam int DC = 1;
  localparam int IC = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              ic_read_req = 1'b0, dc_read_req = 1'b0, dc_write_req = 1'b0;
  logic [ADDR_W-1:0] ic_read_addr = '0, dc_read_addr = '0, dc_write_addr = '0;
  logic [LINE_W-1:0] dc_write_data = '0, mem_data_in = '0;
  logic              mem_ack = 1'b0;
  logic              ic_read_ack, dc_read_ack, dc_write_ack, mem_enable, mem_rw;
  logic [LINE_W-1:0] ic_read_data, dc_read_data, mem_data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        acks;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  assign acks = {dc_write_ack, dc_read_ack, ic_read_ack};

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what each requester asked for and what each read port should show.
  logic [ADDR_W-1:0] exp_addr [3];
  logic [LINE_W-1:0] exp_wdata;
  logic [LINE_W-1:0] model_ic_data, model_dc_data;
  bit                model_last_ic;

  typedef struct {
    bit w, r, i;
    int lat;
    int n;
    int o0, o1, o2;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] onehot(input int who);
    return (who == WR) ? 3'b100 : (who == DC) ? 3'b010 : 3'b001;
  endfunction

  // Priority rule: writeback first, then reads (fixed Dcache-first or alternating).
  function automatic int predict(input bit w, input bit r, input bit i);
    if (w) return WR;
`ifdef ARB_ROUND_ROBIN_EN
    if (r && i) return model_last_ic ? DC : IC;
`endif
    if (r) return DC;
    return IC;
  endfunction

  task automatic set_req(input int who, input logic val);
    if (who == WR) dc_write_req = val;
    else if (who == DC) dc_read_req = val;
    else ic_read_req = val;
  endtask

  task automatic set_addr(input int who, input logic [ADDR_W-1:0] a);
    if (who == WR) dc_write_addr = a;
    else if (who == DC) dc_read_addr = a;
    else ic_read_addr = a;
  endtask

  task automatic applyStimulus(input int who, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
    set_addr(who, a);
    exp_addr[who] = a;
    if (who == WR) begin
      dc_write_data = d;
      exp_wdata = d;
    end
    set_req(who, 1'b1);
  endtask

  task automatic checkOutput(input string name);
    check({name, "_enable"}, mem_enable, 1'b0);
    check({name, "_rw"}, mem_rw, 1'b0);
    check({name, "_addr"}, mem_addr, '0);
    check({name, "_wdata"}, mem_data_out, '0);
    check({name, "_acks"}, acks, 3'b000);
    check({name, "_icdata"}, ic_read_data, '0);
    check({name, "_dcdata"}, dc_read_data, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last_ic = 1'b0;
    model_ic_data = '0;
    model_dc_data = '0;
  endtask

  // Acts as memory for one transaction expected to belong to 'who'.
  task automatic serve_one(input int who, input int lat, input logic [LINE_W-1:0] rdata,
                           input bit drop, input bit mutate);
    int n = 0;
    while (mem_enable !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", mem_enable, 1'b1);
    if (mem_enable !== 1'b1) return;
    check("grant_rw", mem_rw, (who == WR));
    check("grant_addr", mem_addr, exp_addr[who]);
    if (who == WR) check("grant_wdata", mem_data_out, exp_wdata);
    if (who != WR) model_last_ic = (who == IC);
    if (mutate) begin
      set_addr(who, ~exp_addr[who]);
      if (who == WR) dc_write_data = ~exp_wdata;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("busy_enable", mem_enable, 1'b1);
      check("busy_addr", mem_addr, exp_addr[who]);
      check("busy_rw", mem_rw, (who == WR));
      if (who == WR) check("busy_wdata", mem_data_out, exp_wdata);
      check("busy_acks", acks, 3'b000);
    end
    mem_ack = 1'b1;
    mem_data_in = rdata;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_data_in = {4{$urandom}};
    if (who == IC) model_ic_data = rdata;
    if (who == DC) model_dc_data = rdata;
    check("ack_onehot", acks, onehot(who));
    check("ack_enable", mem_enable, 1'b0);
    check("ack_icdata", ic_read_data, model_ic_data);
    check("ack_dcdata", dc_read_data, model_dc_data);
    if (drop) set_req(who, 1'b0);
    if (mutate) begin
      exp_addr[who] = ~exp_addr[who];
      if (who == WR) exp_wdata = ~exp_wdata;
    end
    @(negedge clk);
    check("post_acks", acks, 3'b000);
  endtask

  initial begin
    int o[3];
    bit w, r, i;
    int who, n;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset");
    reset = 1'b1;
    model_last_ic = 1'b0;
    model_ic_data = '0;
    model_dc_data = '0;

    // Icache read with two wait cycles and a known line
    applyStimulus(IC, 32'h0000_0040, '0);
    serve_one(IC, 2, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1, 0);

    // Reset in the middle of a Dcache read
    do_reset();
    applyStimulus(DC, 32'h0000_0080, '0);
    n = 0;
    while (mem_enable !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_grant", mem_enable, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid");
    dc_read_req = 1'b0;
    reset = 1'b1;
    model_last_ic = 1'b0;
    model_ic_data = '0;
    model_dc_data = '0;
    applyStimulus(IC, 32'h0000_0044, '0);
    serve_one(IC, 1, {4{$urandom}}, 1, 0);

    // Spurious mem_ack in IDLE, then a Dcache read whose address changes while busy
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("spur_acks", acks, 3'b000);
    check("spur_enable", mem_enable, 1'b0);
    @(negedge clk);
    check("spur_acks2", acks, 3'b000);
    check("spur_enable2", mem_enable, 1'b0);
    applyStimulus(DC, 32'h0000_0200, '0);
    serve_one(DC, 3, {4{$urandom}}, 1, 1);

    // Grant-order table, each entry from a fresh reset
    vecs[0] = '{0, 0, 1, 1, 1, IC, 0, 0};
    vecs[1] = '{0, 1, 0, 2, 1, DC, 0, 0};
    vecs[2] = '{1, 0, 0, 0, 1, WR, 0, 0};
    vecs[3] = '{1, 0, 1, 1, 2, WR, IC, 0};
    vecs[6] = '{1, 1, 0, 2, 2, WR, DC, 0};
`ifdef ARB_ROUND_ROBIN_EN
    vecs[4] = '{1, 1, 1, 0, 3, WR, IC, DC};
    vecs[5] = '{0, 1, 1, 1, 2, IC, DC, 0};
`else
    vecs[4] = '{1, 1, 1, 0, 3, WR, DC, IC};
    vecs[5] = '{0, 1, 1, 1, 2, DC, IC, 0};
`endif
    foreach (vecs[k]) begin
      do_reset();
      if (vecs[k].w) applyStimulus(WR, 32'h0000_0100, {4{32'h1111_1111}});
      if (vecs[k].r) applyStimulus(DC, 32'h0000_0080, '0);
      if (vecs[k].i) applyStimulus(IC, 32'h0000_0040, '0);
      o[0] = vecs[k].o0; o[1] = vecs[k].o1; o[2] = vecs[k].o2;
      for (int j = 0; j < vecs[k].n; j++) serve_one(o[j], vecs[k].lat, {4{$urandom}}, 1, 0);
    end

    // Both read requests held through four grants
    do_reset();
    applyStimulus(DC, 32'h0000_0300, '0);
    applyStimulus(IC, 32'h0000_0400, '0);
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
      who = (g % 2 == 0) ? IC : DC;
`else
      who = DC;
`endif
      check("held_model", predict(0, 1, 1), who);
      serve_one(who, 0, {4{$urandom}}, 0, 0);
    end
    dc_read_req = 1'b0;
    ic_read_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomized request mixes scored against the priority model
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, 7);
      w = n[2]; r = n[1]; i = n[0];
      if (w) applyStimulus(WR, $urandom, {4{$urandom}});
      if (r) applyStimulus(DC, $urandom, '0);
      if (i) applyStimulus(IC, $urandom, '0);
      while (w || r || i) begin
        who = predict(w, r, i);
        serve_one(who, $urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom}, 1,
                  ($urandom_range(0, 3) == 0));
        if (who == WR) w = 0;
        else if (who == DC) r = 0;
        else i = 0;
      end
      if ($urandom_range(0, 4) == 0) begin
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rand_spur_acks", acks, 3'b000);
        check("rand_spur_enable", mem_enable, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
